// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: owns the PC, feeds a combinational imem and registers the result into IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects trap instead of being silently aligned.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        dbg_trap_state
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        free;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap_q, misalign_trap_d;
`endif

  // Handshake: IF/ID transfers on an edge with id_valid && id_ready; while
  // id_valid && !id_ready the IF/ID contents and the PC hold.
  assign free = !id_valid_q || id_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_trap_d = misalign_trap_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          // A redirect flushes IF/ID even when decode is stalling.
          id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect_pc[1:0] != 2'b00) begin
            pc_d            = redirect_pc;
            misalign_trap_d = 1'b1;
            state_d         = ST_TRAP;
          end else
`endif
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (free) begin
          id_instr_d    = imem_rd;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_q + 32'd4;
          id_valid_d    = 1'b1;
          pc_d          = pc_q + 32'd4;
        end
      end
      ST_TRAP: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_trap_q <= 1'b0;
    end else begin
      misalign_trap_q <= misalign_trap_d;
    end
  end

  assign misalign_trap = misalign_trap_q;
`endif

  assign imem_a         = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign dbg_trap_state = (state_q == ST_TRAP);

endmodule
